// File: rtl/conv_pkg.sv
// Shared definitions for the shift-register convolution block.
// Contents:
//   conv_ctrl_state_t  controller FSM state
//   result_w/result_h  output feature map size for a stride-1 valid convolution
//   bank_depth         words per row-interleaved image bank
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } conv_ctrl_state_t;

  function automatic int result_w(input int img_w, input int filter_l);
    return img_w - filter_l + 1;
  endfunction

  function automatic int result_h(input int img_h, input int filter_l);
    return img_h - filter_l + 1;
  endfunction

  // Rows are spread round-robin over filter_l banks, so each bank holds
  // ceil(img_h / filter_l) full image rows.
  function automatic int bank_depth(input int img_h, input int img_w, input int filter_l);
    return ((img_h + filter_l - 1) / filter_l) * img_w;
  endfunction

endpackage

// File: rtl/conv_ctrl_bank_addr.sv
// Per-bank image read address generation.
// Holds one base register per bank plus the row rotation counter.
// Ports:
//   clk, reset   clock, async active-high reset
//   clear        zero all bases and the rotation counter (idle)
//   wrap         advance to the next output row on this edge
//   col_next     column of the read being issued on this edge
//   rot          current output row mod FILTER_L
//   addr_next    per-bank address of the read being issued (base + column)
module conv_ctrl_bank_addr #(
  parameter int IMG_W    = 16,
  parameter int FILTER_L = 3,
  parameter int COL_W    = 4,
  parameter int BANK_AW  = 7,
  parameter int ROT_W    = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              wrap,
  input  logic [COL_W-1:0]                  col_next,
  output logic [ROT_W-1:0]                  rot,
  output logic [FILTER_L-1:0][BANK_AW-1:0]  addr_next
);

  logic [FILTER_L-1:0][BANK_AW-1:0] base;
  logic [FILTER_L-1:0][BANK_AW-1:0] base_nxt;

  // On a row wrap the bank holding the row that just left the window
  // (row r, bank r mod FILTER_L) steps down one bank row so it now
  // supplies row r+FILTER_L. The address for the read issued on the same
  // edge must already see the updated base.
  always_comb begin
    base_nxt  = base;
    addr_next = '0;
    for (int b = 0; b < FILTER_L; b++) begin
      if (clear)
        base_nxt[b] = '0;
      else if (wrap && rot == ROT_W'(b))
        base_nxt[b] = base[b] + BANK_AW'(IMG_W);
      addr_next[b] = base_nxt[b] + BANK_AW'(col_next);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base <= '0;
      rot  <= '0;
    end else begin
      base <= base_nxt;
      if (clear)
        rot <= '0;
      else if (wrap)
        rot <= (rot == ROT_W'(FILTER_L - 1)) ? '0 : rot + ROT_W'(1);
    end
  end

endmodule

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Control FSM for the fast shift-register convolution datapath.
// Walks the output map row by row, issuing one column read per cycle to
// FILTER_L row-interleaved image banks, and tags each read (shift enable,
// window-complete, row rotation, result address) one cycle later to line
// up with BRAM read data.
// Ports:
//   clk, reset               clock, async active-high reset
//   start/busy/done          handshake with the layer sequencer
//   last_val                 final result write seen by the datapath
//   img_rden, img_rdaddr     common read enable, bank b address in slice b
//   dpath_wren/sum_en        column shift / window complete
//   dpath_rotation_offset    output row mod FILTER_L
//   dpath_result_wraddr      result RAM address for this shift
module conv_bram_sr_fast_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W                 = 16,
  parameter int IMG_H                 = 16,
  parameter int FILTER_L              = 3,
  parameter int RESULT_W              = result_w(IMG_W, FILTER_L),
  parameter int RESULT_H              = result_h(IMG_H, FILTER_L),
  parameter int FILTER_L_ADDR_WIDTH   = $clog2(FILTER_L),
  parameter int IMG_BANK_ADDR_WIDTH   = $clog2(bank_depth(IMG_H, IMG_W, FILTER_L)),
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    img_rden,
  output logic [FILTER_L*IMG_BANK_ADDR_WIDTH-1:0] img_rdaddr,
  output logic                                    dpath_wren,
  output logic                                    dpath_sum_en,
  output logic [FILTER_L_ADDR_WIDTH-1:0]          dpath_rotation_offset,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]        dpath_result_wraddr,
  input  logic                                    last_val
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
  localparam int RAW   = RESULT_RAM_ADDR_WIDTH;

  conv_ctrl_state_t state;

  // c, r, rot and wr_cnt describe the read currently on img_rden.
  logic [COL_W-1:0] c;
  logic [ROW_W-1:0] r;
  logic [RAW-1:0]   row_start;
  logic [RAW-1:0]   wr_cnt;

  logic                                          issue;
  logic                                          wrap;
  logic                                          clear;
  logic [COL_W-1:0]                              col_next;
  logic [FILTER_L_ADDR_WIDTH-1:0]                rot;
  logic [FILTER_L-1:0][IMG_BANK_ADDR_WIDTH-1:0]  addr_next;

  logic last_c, last_r, primed;
  assign last_c = (c == COL_W'(IMG_W - 1));
  assign last_r = (r == ROW_W'(RESULT_H - 1));
  assign primed = (c >= COL_W'(FILTER_L - 1));

  // Decide which read (if any) goes out on the next cycle.
  always_comb begin
    issue    = 1'b0;
    wrap     = 1'b0;
    clear    = 1'b0;
    col_next = '0;
    unique case (state)
      ST_IDLE: begin
        clear = 1'b1;
        issue = start;
      end
      ST_READ: begin
        if (!last_val) begin
          if (!last_c) begin
            issue    = 1'b1;
            col_next = c + COL_W'(1);
          end else if (!last_r) begin
            issue = 1'b1;
            wrap  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  conv_ctrl_bank_addr #(
    .IMG_W    (IMG_W),
    .FILTER_L (FILTER_L),
    .COL_W    (COL_W),
    .BANK_AW  (IMG_BANK_ADDR_WIDTH),
    .ROT_W    (FILTER_L_ADDR_WIDTH)
  ) u_bank_addr (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wrap      (wrap),
    .col_next  (col_next),
    .rot       (rot),
    .addr_next (addr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      c                     <= '0;
      r                     <= '0;
      row_start             <= '0;
      wr_cnt                <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      img_rden              <= 1'b0;
      img_rdaddr            <= '0;
      dpath_wren            <= 1'b0;
      dpath_sum_en          <= 1'b0;
      dpath_rotation_offset <= '0;
      dpath_result_wraddr   <= '0;
    end else begin
      done <= 1'b0;

      // Tag stage: the read on img_rden now has its data next cycle.
      dpath_wren            <= img_rden;
      dpath_sum_en          <= img_rden && primed;
      dpath_rotation_offset <= rot;
      dpath_result_wraddr   <= wr_cnt;

      img_rden <= issue;
      if (issue)
        img_rdaddr <= addr_next;

      unique case (state)
        ST_IDLE: begin
          c         <= '0;
          r         <= '0;
          row_start <= '0;
          wr_cnt    <= '0;
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (last_val) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!last_c) begin
            c <= c + COL_W'(1);
            // Priming shifts all share the row-start address; the counter
            // only moves once the window is full.
            if (primed)
              wr_cnt <= wr_cnt + RAW'(1);
          end else if (!last_r) begin
            c         <= '0;
            r         <= r + ROW_W'(1);
            row_start <= row_start + RAW'(RESULT_W);
            wr_cnt    <= row_start + RAW'(RESULT_W);
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_val) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bram_sr_fast_ctrl.sv
// Self-checking bench for conv_bram_sr_fast_ctrl (5x5 image, 3x3 filter).
// A read-index model predicts every output each cycle; directed scenarios
// pin a few literal values, then a randomized phase exercises start,
// last_val and async reset.
module tb_conv_bram_sr_fast_ctrl;

  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int FL    = 3;
  localparam int RW    = IMG_W - FL + 1;
  localparam int RH    = IMG_H - FL + 1;
  localparam int N     = RH * IMG_W;
  localparam int BAW   = $clog2(((IMG_H + FL - 1) / FL) * IMG_W);
  localparam int FLW   = $clog2(FL);
  localparam int RAW   = $clog2(RW * RH);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 last_val = 1'b0;
  logic                 busy, done, img_rden, dpath_wren, dpath_sum_en;
  logic [FL*BAW-1:0]    img_rdaddr;
  logic [FLW-1:0]       dpath_rotation_offset;
  logic [RAW-1:0]       dpath_result_wraddr;

  conv_bram_sr_fast_ctrl #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .FILTER_L (FL)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .img_rden              (img_rden),
    .img_rdaddr            (img_rdaddr),
    .dpath_wren            (dpath_wren),
    .dpath_sum_en          (dpath_sum_en),
    .dpath_rotation_offset (dpath_rotation_offset),
    .dpath_result_wraddr   (dpath_result_wraddr),
    .last_val              (last_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rd  = 0;
  int n_sum = 0;

  // Model: which read index (k = r*IMG_W + c) is on the read port and on
  // the dpath port, plus the handshake flags.
  logic m_busy = 0, m_done = 0, m_rden = 0, m_wren = 0, m_all_wr = 0;
  int   m_rd_k = 0, m_wr_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Output row r uses image rows r..r+FL-1; the one in bank b sits at
  // bank row h/FL.
  function automatic int exp_bank(input int k, input int b);
    int r, c;
    r = k / IMG_W;
    c = k % IMG_W;
    for (int h = r; h < r + FL; h++)
      if (h % FL == b) return (h / FL) * IMG_W + c;
    return 0;
  endfunction

  function automatic int exp_wraddr(input int k);
    int r, c;
    r = k / IMG_W;
    c = k % IMG_W;
    return r * RW + ((c >= FL - 1) ? c - FL + 1 : 0);
  endfunction

  task automatic model_update(input logic st, input logic lv);
    m_wren = m_rden;
    m_wr_k = m_rd_k;
    m_done = 1'b0;
    if (m_wren && m_wr_k == N - 1) m_all_wr = 1'b1;
    if (!m_busy) begin
      m_rden = 1'b0;
      if (st) begin
        m_busy = 1'b1; m_rden = 1'b1; m_rd_k = 0; m_all_wr = 1'b0;
      end
    end else if (lv) begin
      m_busy = 1'b0; m_done = 1'b1; m_rden = 1'b0;
    end else if (m_rden && m_rd_k < N - 1) begin
      m_rd_k++;
    end else begin
      m_rden = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rden = 0; m_wren = 0; m_all_wr = 0;
    m_rd_k = 0; m_wr_k = 0;
  endtask

  task automatic compare_all();
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("rden", img_rden, m_rden);
    if (m_rden)
      for (int b = 0; b < FL; b++)
        chk($sformatf("rdaddr_b%0d", b), img_rdaddr[b*BAW +: BAW], exp_bank(m_rd_k, b));
    chk("wren", dpath_wren, m_wren);
    chk("sum_en", dpath_sum_en, m_wren && (m_wr_k % IMG_W >= FL - 1));
    if (m_wren) begin
      chk("rot", dpath_rotation_offset, (m_wr_k / IMG_W) % FL);
      chk("wraddr", dpath_result_wraddr, exp_wraddr(m_wr_k));
    end
    if (img_rden) n_rd++;
    if (dpath_sum_en) n_sum++;
  endtask

  // One clock: inputs held across the edge, outputs checked 1 time unit later.
  task automatic step(input logic st, input logic lv);
    start = st;
    last_val = lv;
    @(posedge clk);
    model_update(st, lv);
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, img_rden, 0);
    chk({tag, "_addr"}, img_rdaddr, 0);
    chk({tag, "_wren"}, dpath_wren, 0);
    chk({tag, "_sum"}, dpath_sum_en, 0);
    chk({tag, "_rot"}, dpath_rotation_offset, 0);
    chk({tag, "_wa"}, dpath_result_wraddr, 0);
  endtask

  // Async reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    start = 0;
    last_val = 0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all_zero("rst_now");
    @(posedge clk);
    #1;
    compare_all();
    chk("rst_no_wren", dpath_wren, 0);
    reset = 1'b0;
    cyc++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    reset = 1'b0;

    // Image 1: start at cycle 0, stray start at cycle 6, last_val 3 cycles
    // after the last shift (cycle 16) and a new start in the done cycle.
    cyc = 0; n_rd = 0; n_sum = 0;
    step(1, 0);
    for (int i = 1; i <= 5; i++) step(0, 0);
    step(1, 0);                               // cycle 6, outputs of cycle 7
    chk("pin_r1c1_b0", img_rdaddr[0*BAW +: BAW], 6);
    chk("pin_r1c1_b1", img_rdaddr[1*BAW +: BAW], 1);
    chk("pin_r1c1_b2", img_rdaddr[2*BAW +: BAW], 1);
    for (int i = 7; i <= 14; i++) step(0, 0);
    step(0, 0);                               // outputs of cycle 16
    chk("pin_last_wren", dpath_wren, 1);
    chk("pin_last_wa", dpath_result_wraddr, 8);
    chk("pin_last_rot", dpath_rotation_offset, 2);
    chk("pin_drain_rden", img_rden, 0);
    step(0, 0); step(0, 0); step(0, 0);       // cycles 16..18
    step(0, 1);                               // last_val at cycle 19
    chk("pin_done", done, 1);
    chk("pin_done_busy", busy, 0);
    chk("pin_read_count", n_rd, 15);
    chk("pin_sum_count", n_sum, 9);

    // Image 2 starts in the done cycle, then reset at its cycle 8.
    step(1, 0);
    chk("pin_b2b_rden", img_rden, 1);
    chk("pin_b2b_addr", img_rdaddr, 0);
    for (int i = 1; i <= 7; i++) step(0, 0);
    do_reset();

    // Image 3 replays from scratch.
    n_rd = 0;
    step(1, 0);
    chk("pin_replay_addr", img_rdaddr, 0);
    for (int i = 1; i <= 18; i++) step(0, 0);
    step(0, 1);
    chk("pin_done3", done, 1);
    chk("pin_read_count3", n_rd, 15);

    // Spurious last_val while idle.
    step(0, 0);
    step(0, 1);
    chk("pin_idle_lv_done", done, 0);
    chk("pin_idle_lv_busy", busy, 0);
    step(0, 0);
    chk("pin_idle_lv_done2", done, 0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      logic st, lv;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 2) == 0);
        if (m_all_wr) lv = ($urandom_range(0, 2) == 0);
        else          lv = ($urandom_range(0, 49) == 0);
        step(st, lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_bram_sr_fast_ctrl.md
# conv_bram_sr_fast_ctrl

Control FSM that sits directly upstream of the fast shift-register convolution datapath.
- Walks the output feature map row by row and issues per-bank image BRAM reads.
- Drives the datapath's column-shift enable, row rotation offset and result write address.
- Closes a start/busy/done handshake with the layer sequencer, using the datapath's `last_val` as the completion signal.
- Stride is fixed at 1 in both dimensions.
- The image is held in FILTER_L row-interleaved banks: row h lives in bank h mod FILTER_L, at bank address (h / FILTER_L)·IMG_W + w.

## Interface
Parameters:
- `IMG_W`, 16, image width.
- `IMG_H`, 16, image height.
- `FILTER_L`, 3, square filter side; must be ≥ 2.
- `RESULT_W`, derived: IMG_W−FILTER_L+1.
- `RESULT_H`, derived: IMG_H−FILTER_L+1.
- `FILTER_L_ADDR_WIDTH`, derived: $clog2(FILTER_L).
- `IMG_BANK_ADDR_WIDTH`, derived: $clog2(ceil(IMG_H/FILTER_L)·IMG_W).
- `RESULT_RAM_ADDR_WIDTH`, derived: $clog2(RESULT_W·RESULT_H).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to process one image.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle completion pulse.
- `img_rden` out 1: read enable, common to all banks.
- `img_rdaddr` out FILTER_L·IMG_BANK_ADDR_WIDTH: bank b address in slice b.
- `dpath_wren` out 1: shift one column into the window.
- `dpath_sum_en` out 1: window complete on this shift.
- `dpath_rotation_offset` out FILTER_L_ADDR_WIDTH: r mod FILTER_L for the current output row.
- `dpath_result_wraddr` out RESULT_RAM_ADDR_WIDTH: result address tagged to this shift.
- `last_val` in 1: final result write seen at the datapath output.

## Operation
- **States:** IDLE, READ, DRAIN.
- **IDLE:**
  - `start`=1 → READ.
  - Clear r, c and every bank_base[b].
- **READ:** each cycle issue one read for column c of output row r.
  - `img_rden`=1.
  - `img_rdaddr[b]` = bank_base[b] + c.
- **Column/row advance:**
  - c counts 0..IMG_W−1.
  - On wrap: c←0 and r←r+1.
  - Also on wrap: bank_base[r mod FILTER_L] += IMG_W. That bank now holds row r+FILTER_L; other bases are unchanged.
- **READ exit:** after issuing (r=RESULT_H−1, c=IMG_W−1) → DRAIN. Total reads = RESULT_H·IMG_W.
- **Tagging:** each read is tagged with r, c and rot=r mod FILTER_L, which are delayed one cycle to the dpath outputs.
- **DRAIN:** wait for `last_val`.
- **Completion:** `last_val` sampled high in READ or DRAIN → next cycle `done`=1, `busy`=0, state IDLE.
- **Ignored inputs:**
  - `last_val` in IDLE.
  - `start` while busy (no queueing).
- **Result address for a column shift (r,c):**
  - c ≥ FILTER_L−1 → `dpath_sum_en`=1, address r·RESULT_W + (c−FILTER_L+1).
  - c < FILTER_L−1 (priming) → `dpath_sum_en`=0, address r·RESULT_W. The dpath writes on every wren, so this garbage write is overwritten later by the valid c=FILTER_L−1 write.
- **Arithmetic:**
  - All counters unsigned.
  - rot wraps at FILTER_L, implemented as a counter, not a modulo.
  - The result address is kept as an incrementing counter with a row-start register; no multipliers.

## Timing
- All outputs are registered. Reset value of every output is 0.
- **Read latency:** BRAM read data valid 1 cycle after `img_rden`.
- **Dpath alignment:** `dpath_wren`, `dpath_sum_en`, `dpath_rotation_offset` and `dpath_result_wraddr` are asserted exactly 1 cycle after the matching read.
- **Start latency:**
  - `start` at cycle 0 → `busy` and the first `img_rden` at cycle 1.
  - First `dpath_wren` at cycle 2.
  - Last read at cycle RESULT_H·IMG_W; last `dpath_wren` one cycle later.
- **Throughput:**
  - Reads are back-to-back with no bubble at row wrap.
  - `dpath_wren` is continuous for RESULT_H·IMG_W cycles.
- **Done timing:**
  - `done` is a single cycle.
  - `start` in the `done` cycle is accepted (back-to-back images).
- **Reset mid-operation:**
  - Immediate return to IDLE.
  - All outputs 0 and the in-flight delay stage cleared, so no stray `dpath_wren`.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum `conv_ctrl_state_t`.
  - Derived-width functions RESULT_W/H, which are also used by the datapath.
- Sub-module `conv_ctrl_bank_addr`:
  - FILTER_L bank_base registers, the rotation counter and per-bank address adders.
  - Instantiated once.
- Top level holds the FSM, c/r counters, result-address counter and the 1-cycle tag delay stage.

## Test plan
- **Addressing, IMG 5×5, FILTER_L=3** (result 3×3), start at cycle 0:
  - 15 reads, cycles 1..15.
  - Row 0: bank addresses {c,c,c}.
  - Row 1: bank0 5+c, banks1/2 c.
  - Row 2: banks0/1 5+c, bank2 c.
- **Dpath outputs, same config:**
  - `dpath_rotation_offset` sequence 0×5, 1×5, 2×5.
  - `dpath_sum_en` high 9 times.
  - `dpath_result_wraddr` per row: r·3, r·3, r·3, r·3+1, r·3+2.
- **Completion:** `last_val` pulsed 3 cycles after the last `dpath_wren` → `done` one cycle later, `busy` low with it.
  - A second `start` in the `done` cycle → a new `img_rden` next cycle with all addresses 0.
- **Start while busy:** `start` pulsed at cycle 6 → ignored; the read count stays 15.
- **Reset mid-operation:** async `reset` at cycle 8 (mid row 1) → all outputs 0 immediately, no `dpath_wren` in the following cycle.
  - A fresh `start` then replays the full sequence from address 0.
- **Spurious `last_val` in IDLE** → no `done`, `busy` stays 0.
